// File: rtl/ws2812b_pkg.sv
// Shared types and default 27 MHz timing for the WS2812B serial line driver.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    LATCH,
    IDLE,
    SEND
  } tx_state_t;

  localparam int unsigned DEF_T0H_CYC  = 11;
  localparam int unsigned DEF_T1H_CYC  = 22;
  localparam int unsigned DEF_BIT_CYC  = 34;
  localparam int unsigned DEF_RST_CYC  = 8100;
  localparam int unsigned DEF_NUM_LEDS = 8;

  localparam int unsigned GRB_W = 24;

endpackage

// File: rtl/ws2812b_bit_gen.sv
// One WS2812B bit period: dout high for T0H/T1H cycles, low for the rest of BIT_CYC.
module ws2812b_bit_gen
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H_CYC = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic last_cycle
);

  localparam int unsigned CW = $clog2(BIT_CYC + 1);

  logic [CW-1:0] cnt;
  logic          active;
  logic          bval;

  assign last_cycle = active && (cnt == CW'(BIT_CYC - 1));

  // A start in the last cycle of a bit restarts immediately, giving gapless bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      bval   <= 1'b0;
      dout   <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      bval   <= bit_val;
      dout   <= 1'b1;
    end else if (last_cycle) begin
      cnt    <= '0;
      active <= 1'b0;
      dout   <= 1'b0;
    end else if (active) begin
      cnt  <= cnt + 1'b1;
      dout <= bval ? (cnt < CW'(T1H_CYC - 1)) : (cnt < CW'(T0H_CYC - 1));
    end
  end

endmodule

// File: rtl/ws2812b_tx.sv
// WS2812B strip driver: GRB words in over valid/ready, pulse-width-coded bits out,
// latch period and frame_done pulse after NUM_LEDS words.
module ws2812b_tx
  import ws2812b_pkg::*;
#(
  parameter int unsigned T0H_CYC  = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC  = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC  = DEF_BIT_CYC,
  parameter int unsigned RST_CYC  = DEF_RST_CYC,
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   pix_valid,
  output logic                                                   pix_ready,
  input  logic [GRB_W-1:0]                                       pix_grb,
  output logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0]     pix_idx,
  output logic                                                   dout,
  output logic                                                   busy,
  output logic                                                   frame_done
);

  localparam int unsigned IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned MAXC = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC &&
        RST_CYC >= 1 && NUM_LEDS >= 1)) begin : g_bad_params
    $error("ws2812b_tx: illegal timing or LED-count parameters");
  end

  tx_state_t         state;
  logic [GRB_W-1:0]  shreg;
  logic [4:0]        bitcnt;
  logic [CW-1:0]     lcnt;
  logic              post_rst;
  logic              bit_last;
  logic              more_leds;
  logic              accept;
  logic              start;
  logic              bit_val;

  assign more_leds = pix_idx < IW'(NUM_LEDS - 1);

  // Decoded purely from registers so the next word can be taken in the last
  // cycle of bit 0 without a bubble.
  assign pix_ready = (state == IDLE) ||
                     (state == SEND && bit_last && bitcnt == '0 && more_leds);
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state != IDLE);
  assign start     = accept || (state == SEND && bit_last && bitcnt != '0);
  assign bit_val   = accept ? pix_grb[GRB_W-1] : shreg[GRB_W-1];

  ws2812b_bit_gen #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_val    (bit_val),
    .dout       (dout),
    .last_cycle (bit_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LATCH;
      shreg      <= '0;
      bitcnt     <= '0;
      lcnt       <= '0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
      post_rst   <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LATCH: begin
          if (lcnt == CW'(RST_CYC - 1)) begin
            state    <= IDLE;
            lcnt     <= '0;
            post_rst <= 1'b0;
          end else begin
            lcnt <= lcnt + 1'b1;
            if (lcnt + 1'b1 == CW'(RST_CYC - 1)) begin
              frame_done <= !post_rst;
              pix_idx    <= '0;
            end
          end
        end
        IDLE: begin
          if (accept) begin
            shreg  <= {pix_grb[GRB_W-2:0], 1'b0};
            bitcnt <= 5'(GRB_W - 1);
            state  <= SEND;
          end
        end
        SEND: begin
          if (bit_last) begin
            if (bitcnt != '0) begin
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - 1'b1;
            end else if (more_leds) begin
              pix_idx <= pix_idx + 1'b1;
              if (accept) begin
                shreg  <= {pix_grb[GRB_W-2:0], 1'b0};
                bitcnt <= 5'(GRB_W - 1);
              end else begin
                state <= IDLE;
              end
            end else begin
              state <= LATCH;
              lcnt  <= '0;
              // A one-cycle latch is also its own final cycle.
              if (RST_CYC == 1) begin
                frame_done <= 1'b1;
                pix_idx    <= '0;
              end
            end
          end
        end
        default: state <= LATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_tx.sv
// Self-checking bench for ws2812b_tx against a time-arithmetic reference model.
module tb_ws2812b_tx;

  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int BITC     = 6;
  localparam int RSTC     = 10;
  localparam int NL       = 2;
  localparam int WORD_CYC = 24 * BITC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_grb = '0;
  logic        pix_ready;
  logic [0:0]  pix_idx;
  logic        dout;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  ws2812b_tx #(
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .BIT_CYC  (BITC),
    .RST_CYC  (RSTC),
    .NUM_LEDS (NL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_grb    (pix_grb),
    .pix_idx    (pix_idx),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: what is on the line is a function of the cycle number
  // relative to the start of the current word or latch period.
  int          cyc    = 0;
  bit          m_word = 1'b0;
  bit          m_latch = 1'b1;
  bit          report = 1'b0;
  int          w0     = 0;
  int          lat0   = 0;
  int          midx   = 0;
  logic [23:0] wdata  = '0;
  logic        e_dout, e_ready, e_busy, e_fd;
  int          e_idx;
  int          hi_cnt = 0;
  int          fd_cnt = 0;

  typedef struct {
    int         off;
    logic       dout;
    logic       ready;
    logic       busy;
    logic [0:0] idx;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic predict();
    int  off;
    int  n;
    bit  last;
    e_fd  = 1'b0;
    e_idx = midx;
    if (m_latch) begin
      last    = (cyc == lat0 + RSTC - 1);
      e_dout  = 1'b0;
      e_ready = 1'b0;
      e_busy  = 1'b1;
      e_fd    = last && report;
      if (last) e_idx = 0;
    end else if (m_word) begin
      off     = cyc - w0;
      n       = 23 - off / BITC;
      e_dout  = (off % BITC) < (wdata[n] ? T1H : T0H);
      e_ready = (off == WORD_CYC - 1) && (midx < NL - 1);
      e_busy  = 1'b1;
    end else begin
      e_dout  = 1'b0;
      e_ready = 1'b1;
      e_busy  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int off;
    predict();
    off = cyc - w0;
    if (rst) begin
      m_latch = 1'b1;
      m_word  = 1'b0;
      lat0    = cyc + 1;
      report  = 1'b0;
      midx    = 0;
    end else if (e_ready && pix_valid) begin
      if (m_word) midx++;
      m_word  = 1'b1;
      m_latch = 1'b0;
      w0      = cyc + 1;
      wdata   = pix_grb;
    end else if (m_word && off == WORD_CYC - 1) begin
      m_word = 1'b0;
      if (midx < NL - 1) midx++;
      else begin
        m_latch = 1'b1;
        lat0    = cyc + 1;
        report  = 1'b1;
      end
    end else if (m_latch && cyc == lat0 + RSTC - 1) begin
      m_latch = 1'b0;
      midx    = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    predict();
    check("dout", dout, e_dout);
    check("pix_ready", pix_ready, e_ready);
    check("busy", busy, e_busy);
    check("frame_done", frame_done, e_fd);
    check("pix_idx", pix_idx, e_idx);
    hi_cnt += int'(dout);
    fd_cnt += int'(frame_done);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;

    // Word 24'hA500FF: bit23=1, bit22=0, bit21=1, bit0=1; offsets from accept cycle.
    tbl[0]  = '{1,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{4,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5,   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{6,   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{7,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{8,   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{9,   1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{12,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{13,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{142, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{143, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{144, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{145, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset and post-reset latch
    tick();
    check("rst_dout", dout, 1'b0);
    check("rst_ready", pix_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    check("rst_latch_len", n, 10);
    check("rst_idle_busy", busy, 1'b0);
    check("rst_idle_idx", pix_idx, 1'b0);
    check("rst_no_frame_done", fd_cnt, 0);

    // Single word, table-driven waveform checks
    pix_grb   = 24'hA500FF;
    pix_valid = 1'b1;
    k = cyc;
    tick();
    pix_valid = 1'b0;
    pix_grb   = 24'h000000;
    for (int i = 0; i < 13; i++) begin
      while (cyc < k + tbl[i].off) tick();
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      check($sformatf("tbl%0d_ready", i), pix_ready, tbl[i].ready);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d_idx", i), pix_idx, tbl[i].idx);
    end

    // Stall between words, then late word
    repeat (20) tick();
    check("stall_dout", dout, 1'b0);
    check("stall_ready", pix_ready, 1'b1);
    check("stall_idx", pix_idx, 1'b1);
    pix_grb   = 24'h12F00F;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    check("stall_rise", dout, 1'b1);
    fd_cnt = 0;
    n = 0;
    while (fd_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    check("stall_frame_done", fd_cnt, 1);
    tick();
    check("stall_end_busy", busy, 1'b0);
    check("stall_end_idx", pix_idx, 1'b0);

    // Back-to-back frame
    pix_grb   = 24'hFFFFFF;
    pix_valid = 1'b1;
    k = cyc;
    hi_cnt = 0;
    fd_cnt = 0;
    tick();
    pix_grb = 24'h000000;
    while (cyc < k + WORD_CYC) tick();
    check("b2b_ready_last_bit0", pix_ready, 1'b1);
    tick();
    pix_valid = 1'b0;
    check("b2b_no_gap", dout, 1'b1);
    while (cyc < k + 2 * WORD_CYC) tick();
    check("b2b_high_cycles", hi_cnt, 24 * T1H + 24 * T0H);
    while (cyc < k + 2 * WORD_CYC + RSTC - 1) tick();
    check("b2b_fd_early", fd_cnt, 0);
    tick();
    check("b2b_frame_done", frame_done, 1'b1);
    check("b2b_idx_zero", pix_idx, 1'b0);
    tick();
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_ready", pix_ready, 1'b1);

    // Input isolation during SEND
    pix_grb   = 24'h5A3C96;
    pix_valid = 1'b1;
    k = cyc;
    hi_cnt = 0;
    tick();
    pix_valid = 1'b0;
    while (cyc < k + WORD_CYC) begin
      if (cyc - k >= 10 && cyc - k <= 120 && (cyc % 7) == 0) begin
        pix_valid = 1'b1;
        pix_grb   = $urandom;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
    end
    pix_valid = 1'b0;
    check("iso_high_cycles", hi_cnt, 12 * T1H + 12 * T0H);
    tick();
    check("iso_no_accept", busy, 1'b0);
    check("iso_idx", pix_idx, 1'b1);

    // Reset while dout is high in word 1
    pix_grb   = 24'hC3C3C3;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    check("rstmid_pre", dout, 1'b1);
    rst = 1'b1;
    fd_cnt = 0;
    tick();
    rst = 1'b0;
    check("rstmid_dout", dout, 1'b0);
    n = 0;
    while (!pix_ready && n < 50) begin
      tick();
      n++;
    end
    check("rstmid_latch_len", n, 10);
    check("rstmid_no_fd", fd_cnt, 0);
    check("rstmid_idx", pix_idx, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_grb   = $urandom;
      rst       = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst       = 1'b0;
    pix_valid = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
